// File: rtl/adding_machine_controller_pkg.sv
// Shared definitions for the adding-machine control unit: opcodes, FSM states
// and a classification helper used by the controller.
package adding_machine_controller_pkg;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // ERR carries the 4th bit; its low three bits read 7 on the debug port,
  // distinguished from JMP by bus_error.
  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_IDLE   = 4'd1,
    ST_FETCH  = 4'd2,
    ST_DECODE = 4'd3,
    ST_LDA    = 4'd4,
    ST_STA    = 4'd5,
    ST_ADD    = 4'd6,
    ST_JMP    = 4'd7,
    ST_ERR    = 4'd15
  } am_state_e;

  // States that hold a memory request open and may wait on mem_ready.
  function automatic logic is_mem_state(am_state_e s);
    return (s == ST_FETCH) || (s == ST_LDA) || (s == ST_STA) || (s == ST_ADD);
  endfunction

endpackage

// File: rtl/adding_machine_controller_wait_timer.sv
// Memory wait counter with timeout compare. expired is asserted during the
// wait cycle that brings the count up to TIMEOUT, so the owner can leave for
// its fault state on the following edge. TIMEOUT = 0 disables expiry.
module am_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic             ARMED = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Clear wins over count so a completing handshake never leaves residue.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  assign expired = ARMED && en && (cnt_q == LIMIT);

endmodule

// File: rtl/adding_machine_controller.sv
// Control unit for the adding-machine datapath: sequences fetch/decode/execute
// for the 4-instruction ISA and handshakes memory with a bounded wait.
module adding_machine_controller
  import adding_machine_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op_code,
  input  logic       mem_ready,
  input  logic       halt,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass_add,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic       instr_done,
  output logic       bus_error,
  output logic [2:0] state
);

  am_state_e state_q;
  am_state_e state_d;
  logic      in_mem;
  logic      timer_expired;

  assign in_mem = is_mem_state(state_q);

  // Leaving a non-memory state always passes through clr, which covers the
  // "clear on entry" rule without tracking transitions explicitly.
  am_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_mem || mem_ready),
    .en      (in_mem && !mem_ready),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RST;
    else       state_q <= state_d;
  end

  // Next-state: halt is only looked at on RST exit and on retire.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:    state_d = halt ? ST_IDLE : ST_FETCH;
      ST_IDLE:   if (!halt) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)          state_d = ST_DECODE;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_DECODE: begin
        unique case (op_code)
          OP_LDA:  state_d = ST_LDA;
          OP_STA:  state_d = ST_STA;
          OP_ADD:  state_d = ST_ADD;
          default: state_d = ST_JMP;
        endcase
      end
      ST_LDA, ST_STA, ST_ADD: begin
        if (mem_ready)          state_d = halt ? ST_IDLE : ST_FETCH;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_JMP:    state_d = halt ? ST_IDLE : ST_FETCH;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_ERR;
    endcase
  end

  // Output decode from state, with load strobes qualified by mem_ready.
  always_comb begin
    ir_on_adr  = 1'b0;
    pc_on_adr  = 1'b0;
    ld_ir      = 1'b0;
    ld_ac      = 1'b0;
    ld_pc      = 1'b0;
    inc_pc     = 1'b0;
    clr_pc     = 1'b0;
    pass_add   = 1'b0;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    instr_done = 1'b0;
    bus_error  = 1'b0;
    unique case (state_q)
      ST_RST:    clr_pc = 1'b1;
      ST_IDLE:   ;
      ST_FETCH: begin
        pc_on_adr = 1'b1;
        rd_mem    = 1'b1;
        ld_ir     = mem_ready;
        inc_pc    = mem_ready;
      end
      ST_DECODE: ir_on_adr = 1'b1;
      ST_LDA: begin
        ir_on_adr  = 1'b1;
        rd_mem     = 1'b1;
        ld_ac      = mem_ready;
        instr_done = mem_ready;
      end
      ST_STA: begin
        ir_on_adr  = 1'b1;
        wr_mem     = 1'b1;
        instr_done = mem_ready;
      end
      ST_ADD: begin
        ir_on_adr  = 1'b1;
        rd_mem     = 1'b1;
        pass_add   = 1'b1;
        ld_ac      = mem_ready;
        instr_done = mem_ready;
      end
      ST_JMP: begin
        ld_pc      = 1'b1;
        instr_done = 1'b1;
      end
      ST_ERR:    bus_error = 1'b1;
      default:   bus_error = 1'b1;
    endcase
  end

  assign state = state_q[2:0];

endmodule

// File: tb/tb_adding_machine_controller.sv
// Directed bench for adding_machine_controller with a per-cycle reference model.
module tb_adding_machine_controller;

  localparam int unsigned TIMEOUT = 16;

  localparam logic [1:0] T_LDA = 2'b00;
  localparam logic [1:0] T_STA = 2'b01;
  localparam logic [1:0] T_ADD = 2'b10;
  localparam logic [1:0] T_JMP = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] op_code = 2'b00;
  logic       mem_ready = 1'b1;
  logic       halt = 1'b0;
  logic       ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc;
  logic       pass_add, rd_mem, wr_mem, instr_done, bus_error;
  logic [2:0] state;

  always #5 clk = ~clk;

  adding_machine_controller #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_code    (op_code),
    .mem_ready  (mem_ready),
    .halt       (halt),
    .ir_on_adr  (ir_on_adr),
    .pc_on_adr  (pc_on_adr),
    .ld_ir      (ld_ir),
    .ld_ac      (ld_ac),
    .ld_pc      (ld_pc),
    .inc_pc     (inc_pc),
    .clr_pc     (clr_pc),
    .pass_add   (pass_add),
    .rd_mem     (rd_mem),
    .wr_mem     (wr_mem),
    .instr_done (instr_done),
    .bus_error  (bus_error),
    .state      (state)
  );

  logic [14:0] dut_vec;
  assign dut_vec = {ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc,
                    pass_add, rd_mem, wr_mem, instr_done, bus_error, state};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: where the machine is in the instruction cycle, which
  // opcode is executing, and how many cycles the current access has waited.
  localparam int P_BOOT = 0, P_IDLE = 1, P_FETCH = 2, P_DEC = 3, P_EXEC = 4, P_ERR = 5;
  int         m_ph    = P_BOOT;
  logic [1:0] m_op    = 2'b00;
  int         m_waits = 0;

  function automatic logic [14:0] model_out(input int ph, input logic [1:0] op, input logic mr);
    logic ir_a, pc_a, lir, lac, lpc, ipc, cpc, padd, rd, wr, done, berr;
    logic [2:0] st;
    {ir_a, pc_a, lir, lac, lpc, ipc, cpc, padd, rd, wr, done, berr} = '0;
    st = 3'd0;
    case (ph)
      P_BOOT:  begin cpc = 1'b1; st = 3'd0; end
      P_IDLE:  st = 3'd1;
      P_FETCH: begin pc_a = 1'b1; rd = 1'b1; lir = mr; ipc = mr; st = 3'd2; end
      P_DEC:   begin ir_a = 1'b1; st = 3'd3; end
      P_EXEC: begin
        st = {1'b1, op};
        if (op == T_JMP) begin
          lpc = 1'b1; done = 1'b1;
        end else begin
          ir_a = 1'b1;
          done = mr;
          if (op == T_STA) wr = 1'b1;
          else begin rd = 1'b1; lac = mr; padd = (op == T_ADD); end
        end
      end
      default: begin berr = 1'b1; st = 3'd7; end
    endcase
    return {ir_a, pc_a, lir, lac, lpc, ipc, cpc, padd, rd, wr, done, berr, st};
  endfunction

  task automatic model_wait();
    m_waits++;
    if (TIMEOUT > 0 && m_waits >= int'(TIMEOUT)) m_ph = P_ERR;
  endtask

  task automatic model_step();
    if (reset) begin
      m_ph = P_BOOT; m_waits = 0;
    end else begin
      case (m_ph)
        P_BOOT:  begin m_ph = halt ? P_IDLE : P_FETCH; m_waits = 0; end
        P_IDLE:  if (!halt) begin m_ph = P_FETCH; m_waits = 0; end
        P_FETCH: if (mem_ready) m_ph = P_DEC; else model_wait();
        P_DEC:   begin m_ph = P_EXEC; m_op = op_code; m_waits = 0; end
        P_EXEC: begin
          if (m_op == T_JMP || mem_ready) begin
            m_ph = halt ? P_IDLE : P_FETCH; m_waits = 0;
          end else model_wait();
        end
        default: m_ph = P_ERR;
      endcase
    end
  endtask

  // Compare on every falling edge; advance the model on every rising edge.
  initial begin
    @(posedge clk);
    model_step();
    forever begin
      @(negedge clk);
      chkv("outputs", dut_vec, model_out(m_ph, m_op, mem_ready));
      chk1("inv_adr_bus", ir_on_adr & pc_on_adr, 1'b0);
      chk1("inv_rd_wr", rd_mem & wr_mem, 1'b0);
      chk1("inv_ld_ir_ac", ld_ir & ld_ac, 1'b0);
      chk1("inv_clr_pc", clr_pc & (inc_pc | ld_pc), 1'b0);
      @(posedge clk);
      model_step();
    end
  end

  // nx: step into the next cycle (inputs may be changed after it).
  // mid: move to the middle of the current cycle for literal checks.
  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    // Reset, then LDA with zero-wait memory.
    nx(); nx(); reset = 1'b0;
    mid(); chk3("rst_state", state, 3'd0); chk1("rst_clr_pc", clr_pc, 1'b1);
    nx(); mid(); chk3("f1_state", state, 3'd2); chk1("f1_ld_ir", ld_ir, 1'b1); chk1("f1_inc_pc", inc_pc, 1'b1);
    nx(); mid(); chk3("d1_state", state, 3'd3); chk1("d1_ir_on_adr", ir_on_adr, 1'b1);
    nx(); mid(); chk3("lda_state", state, 3'd4); chk1("lda_ld_ac", ld_ac, 1'b1); chk1("lda_done", instr_done, 1'b1);

    // STA with three wait cycles.
    nx(); op_code = T_STA; mid(); chk3("f2_state", state, 3'd2);
    nx(); mem_ready = 1'b0; mid(); chk3("d2_state", state, 3'd3);
    nx();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk3("sta_w_state", state, 3'd5); chk1("sta_w_wr", wr_mem, 1'b1);
      chk1("sta_w_ir_adr", ir_on_adr, 1'b1); chk1("sta_w_rd", rd_mem, 1'b0);
      chk1("sta_w_done", instr_done, 1'b0);
      nx();
    end
    mem_ready = 1'b1;
    mid(); chk1("sta_wr", wr_mem, 1'b1); chk1("sta_rd", rd_mem, 1'b0); chk1("sta_done", instr_done, 1'b1);

    // JMP.
    nx(); op_code = T_JMP; mid(); chk3("f3_state", state, 3'd2);
    nx(); mid(); chk3("d3_state", state, 3'd3);
    nx(); mid();
    chk3("jmp_state", state, 3'd7); chk1("jmp_ld_pc", ld_pc, 1'b1); chk1("jmp_rd", rd_mem, 1'b0);
    chk1("jmp_wr", wr_mem, 1'b0); chk1("jmp_done", instr_done, 1'b1); chk1("jmp_berr", bus_error, 1'b0);
    nx(); mid(); chk3("post_jmp_state", state, 3'd2); chk1("post_jmp_ld_pc", ld_pc, 1'b0);

    // ADD with halt raised during its wait.
    nx(); mem_ready = 1'b0; op_code = T_ADD; mid(); chk3("d4_state", state, 3'd3);
    nx(); mid(); chk3("add_w1_state", state, 3'd6); chk1("add_w1_pass", pass_add, 1'b1); chk1("add_w1_ld_ac", ld_ac, 1'b0);
    nx(); halt = 1'b1; mid(); chk1("add_w2_done", instr_done, 1'b0);
    nx(); mem_ready = 1'b1; mid();
    chk3("add_state", state, 3'd6); chk1("add_ld_ac", ld_ac, 1'b1); chk1("add_pass", pass_add, 1'b1); chk1("add_done", instr_done, 1'b1);
    nx(); mid(); chk3("idle_state", state, 3'd1); chkv("idle_outs", {dut_vec[14:3], 3'd0}, 15'd0);
    nx(); halt = 1'b0; mid(); chk3("idle2_state", state, 3'd1);
    nx(); mid(); chk3("unhalt_state", state, 3'd2);

    // Reset in the middle of an LDA wait.
    op_code = T_LDA;
    nx(); mem_ready = 1'b0; mid(); chk3("d5_state", state, 3'd3);
    nx(); mid(); chk3("lda_w_state", state, 3'd4); chk1("lda_w_rd", rd_mem, 1'b1); chk1("lda_w_ld_ac", ld_ac, 1'b0);
    nx(); reset = 1'b1; mid(); chk1("lda_w2_ld_ac", ld_ac, 1'b0);
    nx(); reset = 1'b0; mid();
    chk3("rst2_state", state, 3'd0); chk1("rst2_rd", rd_mem, 1'b0); chk1("rst2_ld_ac", ld_ac, 1'b0); chk1("rst2_clr", clr_pc, 1'b1);

    // Fetch timeout: 16 wait cycles, then sticky ERR until reset.
    nx();
    for (int i = 0; i < 16; i++) begin
      mid(); chk3("to_w_state", state, 3'd2); chk1("to_w_berr", bus_error, 1'b0);
      nx();
    end
    mid(); chk3("err_state", state, 3'd7); chk1("err_berr", bus_error, 1'b1);
    chk1("err_rd", rd_mem, 1'b0); chk1("err_ld_pc", ld_pc, 1'b0);
    nx(); mem_ready = 1'b1;
    nx(); mid(); chk3("err2_state", state, 3'd7); chk1("err2_berr", bus_error, 1'b1);

    // Reset while halted: RST then IDLE, resume on halt release.
    nx(); reset = 1'b1; halt = 1'b1;
    nx(); reset = 1'b0; mid();
    chk3("rst3_state", state, 3'd0); chk1("rst3_berr", bus_error, 1'b0); chk1("rst3_clr", clr_pc, 1'b1);
    nx(); mid(); chk3("idle3_state", state, 3'd1);
    nx(); halt = 1'b0;
    nx(); mid(); chk3("resume_state", state, 3'd2);
    nx(); nx();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
